gpu_fill_engine: RTL and testbench
==================================

Name: gpu_fill_engine

Overview:
- Downstream of the GPU register block: turns one latched draw command (x, y, colour, length) into page-safe SDRAM write bursts toward the SDRAM/HDMI framebuffer controller.
- Computes the linear framebuffer address and splits the run into bursts that never exceed MAX_BURST or cross a PAGE boundary.
- Streams the constant colour and reports busy/done back to the register block.

Parameters:
- H_RES, 1024, framebuffer width in pixels.
- V_RES, 768, framebuffer height in pixels.
- ADDR_W, 20, framebuffer word-address width.
- MAX_BURST, 256, maximum words per burst (at most 256; wr_len is 9 bits).
- PAGE, 256, SDRAM page size in words (power of two); no burst crosses a page.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- x_pos  in  16  start column.
- y_pos  in  16  start row.
- pixel  in  24  fill colour, RGB888.
- len  in  24  number of pixels to write.
- enable  in  1  level command request; a rising edge starts a command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the command completes.
- wr_req  out  1  burst request to the SDRAM controller.
- wr_addr  out  ADDR_W  burst start word address.
- wr_len  out  9  burst length in words, 1..MAX_BURST.
- wr_ack  in  1  controller accepted the burst (single cycle).
- wr_data_req  in  1  controller pulls one word this cycle.
- wr_data  out  24  write data (latched pixel).

Behaviour:
- Reset (async, rstn=0): state IDLE; busy, done, wr_req = 0; wr_addr, wr_len, wr_data = 0; internal enable_q = 0.
- Start detection: registered edge detect, start = enable & ~enable_q.
  - Edges while busy are ignored.
  - A level held high across completion does not retrigger.
- States:
  - IDLE: on start, latch x, y, pixel, len; go to CALC; busy=1 from this edge.
  - CALC: cur_addr = y_pos*H_RES + x_pos, truncated to ADDR_W; remaining = len.
    - remaining==0: go to FIN.
    - Otherwise go to REQ.
  - REQ: wr_req=1.
    - wr_len = min(remaining, MAX_BURST, PAGE - (cur_addr mod PAGE)).
    - wr_addr = cur_addr.
    - wr_addr and wr_len are registered on entry and stable while wr_req=1.
    - On wr_ack: wr_req=0 the next cycle; go to DATA; clear the beat counter.
  - DATA: each cycle with wr_data_req=1, beat counter +1 and wr_data = pixel.
    - On the beat where count reaches wr_len: cur_addr += wr_len (mod 2^ADDR_W), remaining -= wr_len.
    - Then go to REQ if remaining>0, else FIN.
  - FIN: done=1 for one cycle, busy=0 the same edge; go to IDLE.
- Latency:
  - Start edge at cycle t: CALC at t+1, wr_req first high at t+2.
  - len=0: done high at t+2 and no wr_req at any point.
- wr_data_req outside DATA is ignored; wr_data holds the latched pixel for the whole command.
- wr_ack outside REQ is ignored.
- wr_ack and the last wr_data_req cannot coincide by protocol; no special handling.
- Address arithmetic is unsigned. Without clipping, any address beyond the framebuffer wraps modulo 2^ADDR_W.
- Reset mid-command (any state) aborts immediately: no done pulse; the next command starts cleanly.

Optional Feature:
- Macro: GPU_CLIP_EN.
- Defined:
  - In CALC, if x_pos>=H_RES or y_pos>=V_RES, remaining=0.
  - Otherwise remaining = min(len, H_RES*V_RES - start_addr).
  - Writes never leave the visible framebuffer.
- Not defined: len is used unmodified and addresses wrap as above.

Decomposition:
- Shared package gpu_pkg holds:
  - fill state enum (IDLE, CALC, REQ, DATA, FIN);
  - framebuffer constants H_RES, V_RES, ADDR_W, MAX_BURST, PAGE;
  - pixel width constant (24).
- One natural sub-module, gpu_burst_split: combinational min(remaining, MAX_BURST, page headroom) producing the next wr_len.

Test Plan:
1. x=0, y=0, pixel=0x00FF00, len=256, wr_ack after 3 cycles, wr_data_req continuous -> one burst addr 0, len 256; 256 words of 0x00FF00; one done pulse; busy low afterwards.
2. x=200, y=1, len=100 -> burst 1 addr 1224, len 56; burst 2 addr 1280, len 44; exactly 100 data beats total.
3. len=0 -> wr_req never asserted; done pulses exactly 2 cycles after the enable edge.
4. Hold wr_ack low 10 cycles and pulse enable again while busy -> wr_req, wr_addr, wr_len stable throughout; second edge ignored; only one command's bursts issued.
5. Assert rstn=0 after 30 of 256 beats, then release and issue x=0, y=2, len=8 -> all outputs 0 during reset; no done for the aborted command; new burst addr 2048, len 8.
6. GPU_CLIP_EN defined, x=1000, y=767, len=100 -> 24 words total (addr 786408, len 24), then done. Undefined -> 100 words total, split at the page boundary into 24 + 76.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared framebuffer constants and fill-engine state encoding
package gpu_pkg;
   localparam int H_RES     = 1024;
   localparam int V_RES     = 768;
   localparam int ADDR_W    = 20;
   localparam int MAX_BURST = 256;
   localparam int PAGE      = 256;
   localparam int PIX_W     = 24;
   localparam int LEN_W     = 24;
   localparam int PAGE_BITS = $clog2(PAGE);
   localparam int FB_WORDS  = H_RES * V_RES;

   typedef enum logic [2:0] {IDLE, CALC, REQ, DATA, FIN} fill_state_t;
endpackage

// File: rtl/gpu_burst_split.sv
// rtl/gpu_burst_split.sv - next burst length: min(remaining, MAX_BURST, page headroom)
module gpu_burst_split
   import gpu_pkg::*;
(
   input  logic [PAGE_BITS-1:0] page_off,
   input  logic [LEN_W-1:0]     remaining,
   output logic [8:0]           burst_len
);
   logic [8:0] headroom;
   logic [8:0] cap;

   always_comb begin
      headroom  = 9'(PAGE) - 9'(page_off);
      cap       = (headroom < 9'(MAX_BURST)) ? headroom : 9'(MAX_BURST);
      burst_len = (remaining < LEN_W'(cap)) ? remaining[8:0] : cap;
   end
endmodule

// File: rtl/gpu_fill_engine.sv
// rtl/gpu_fill_engine.sv - draw command to page-safe SDRAM write bursts
// Optional framebuffer clipping: GPU_CLIP_EN.
module gpu_fill_engine
   import gpu_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [15:0]       x_pos,
   input  logic [15:0]       y_pos,
   input  logic [PIX_W-1:0]  pixel,
   input  logic [LEN_W-1:0]  len,
   input  logic              enable,
   output logic              busy,
   output logic              done,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [8:0]        wr_len,
   input  logic              wr_ack,
   input  logic              wr_data_req,
   output logic [PIX_W-1:0]  wr_data
);
   fill_state_t          state, next_state;
   logic                 enable_q, start, last_beat;
   logic [15:0]          x_q, y_q;
   logic [LEN_W-1:0]     len_q, remaining, calc_rem, next_rem, split_rem;
   logic [ADDR_W-1:0]    cur_addr, calc_addr, next_addr;
   logic [PAGE_BITS-1:0] split_off;
   logic [8:0]           beat_cnt, split_len;

   assign start     = enable & ~enable_q;
   assign calc_addr = ADDR_W'(32'(y_q) * 32'(H_RES) + 32'(x_q));
   assign next_addr = cur_addr + ADDR_W'(wr_len);
   assign next_rem  = remaining - LEN_W'(wr_len);
   assign last_beat = wr_data_req && ((beat_cnt + 9'd1) == wr_len);

`ifdef GPU_CLIP_EN
   logic [LEN_W-1:0] room;
   always_comb begin
      room     = LEN_W'(FB_WORDS) - LEN_W'(calc_addr);
      calc_rem = (len_q < room) ? len_q : room;
      if (x_q >= 16'(H_RES) || y_q >= 16'(V_RES))
         calc_rem = '0;
   end
`else
   assign calc_rem = len_q;
`endif

   // CALC feeds the splitter directly so the first burst is registered on REQ entry
   assign split_off = (state == CALC) ? calc_addr[PAGE_BITS-1:0] : next_addr[PAGE_BITS-1:0];
   assign split_rem = (state == CALC) ? calc_rem : next_rem;

   gpu_burst_split u_split (
      .page_off  (split_off),
      .remaining (split_rem),
      .burst_len (split_len)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = CALC;
         CALC: next_state = (calc_rem == '0) ? FIN : REQ;
         REQ:  if (wr_ack) next_state = DATA;
         DATA: if (last_beat) next_state = (next_rem != '0) ? REQ : FIN;
         FIN:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         enable_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_req    <= 1'b0;
         wr_addr   <= '0;
         wr_len    <= '0;
         wr_data   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         len_q     <= '0;
         cur_addr  <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
      end else begin
         enable_q <= enable;
         done     <= 1'b0;
         case (state)
            IDLE: if (start) begin
               x_q     <= x_pos;
               y_q     <= y_pos;
               len_q   <= len;
               wr_data <= pixel;
               busy    <= 1'b1;
            end
            CALC: begin
               cur_addr  <= calc_addr;
               remaining <= calc_rem;
               if (calc_rem == '0) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  wr_req  <= 1'b1;
                  wr_addr <= calc_addr;
                  wr_len  <= split_len;
               end
            end
            REQ: if (wr_ack) begin
               wr_req   <= 1'b0;
               beat_cnt <= '0;
            end
            DATA: if (wr_data_req) begin
               beat_cnt <= beat_cnt + 9'd1;
               if (last_beat) begin
                  cur_addr  <= next_addr;
                  remaining <= next_rem;
                  if (next_rem != '0) begin
                     wr_req  <= 1'b1;
                     wr_addr <= next_addr;
                     wr_len  <= split_len;
                  end else begin
                     done <= 1'b1;
                     busy <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_gpu_fill_engine.sv
// tb/tb_gpu_fill_engine.sv - directed self-checking bench for gpu_fill_engine
module tb_gpu_fill_engine;
   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [15:0] x_pos = '0, y_pos = '0;
   logic [23:0] pixel = '0, len = '0;
   logic        enable = 1'b0, wr_ack = 1'b0, wr_data_req = 1'b0;
   logic        busy, done, wr_req;
   logic [19:0] wr_addr;
   logic [8:0]  wr_len;
   logic [23:0] wr_data;
   int          total = 0;
   int          bad = 0;

   gpu_fill_engine dut (
      .clk(clk), .rstn(rstn), .x_pos(x_pos), .y_pos(y_pos), .pixel(pixel), .len(len),
      .enable(enable), .busy(busy), .done(done), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_len(wr_len), .wr_ack(wr_ack), .wr_data_req(wr_data_req), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Leaves the bench at the negedge two cycles after the enable edge
   task automatic start_cmd(input int x, input int y, input logic [23:0] pix, input int n);
      @(negedge clk);
      x_pos = 16'(x); y_pos = 16'(y); pixel = pix; len = 24'(n); enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      x_pos = 16'h3c3; y_pos = 16'h1a5; pixel = 24'hdeadbe; len = 24'd999;
      check("calc_busy", 32'(busy), 1);
      check("calc_req", 32'(wr_req), 0);
      @(negedge clk);
      check("lat_req", 32'(wr_req), (n != 0) ? 1 : 0);
      check("lat_done", 32'(done), (n == 0) ? 1 : 0);
   endtask

   task automatic wait_req();
      int n = 0;
      while (wr_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", 32'(wr_req), 1);
   endtask

   task automatic serve(input int ea, input int el, input int dly, input logic [23:0] pix,
                        input bit poke);
      wait_req();
      check("addr", 32'(wr_addr), 32'(ea));
      check("len", 32'(wr_len), 32'(el));
      for (int i = 0; i < dly; i++) begin
         if (poke && i == 3) enable = 1'b1;
         if (poke && i == 5) enable = 1'b0;
         @(negedge clk);
         check("hold_req", 32'(wr_req), 1);
         check("hold_addr", 32'(wr_addr), 32'(ea));
         check("hold_len", 32'(wr_len), 32'(el));
      end
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      check("ack_drop", 32'(wr_req), 0);
      wr_data_req = 1'b1;
      for (int i = 0; i < el; i++) begin
         check("wdata", 32'(wr_data), 32'(pix));
         check("in_data", 32'({wr_req, done}), 0);
         @(negedge clk);
      end
      wr_data_req = 1'b0;
   endtask

   task automatic finish_cmd();
      check("done", 32'(done), 1);
      check("busy_low", 32'(busy), 0);
      check("no_req", 32'(wr_req), 0);
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
   endtask

   initial begin
      #2 rstn = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_req", 32'(wr_req), 0);
      check("rst_addr", 32'(wr_addr), 0);
      check("rst_len", 32'(wr_len), 0);
      check("rst_data", 32'(wr_data), 0);
      @(negedge clk);
      rstn = 1'b1;

      // single full-page burst
      start_cmd(0, 0, 24'h00ff00, 256);
      serve(0, 256, 3, 24'h00ff00, 1'b0);
      finish_cmd();
      repeat (2) @(negedge clk);
      check("t1_idle", 32'(busy), 0);

      // page split 56 + 44
      start_cmd(200, 1, 24'h102030, 100);
      serve(1224, 56, 0, 24'h102030, 1'b0);
      serve(1280, 44, 1, 24'h102030, 1'b0);
      finish_cmd();

      // zero length: done two cycles after the edge, no request
      start_cmd(5, 5, 24'h777777, 0);
      check("z_busy", 32'(busy), 0);
      @(negedge clk);
      check("z_done_off", 32'(done), 0);
      check("z_req", 32'(wr_req), 0);

      // long ack stall with a second enable edge while busy
      start_cmd(16, 3, 24'habcdef, 16);
      serve(3088, 16, 10, 24'habcdef, 1'b1);
      finish_cmd();
      for (int i = 0; i < 6; i++) begin
         check("t4_no_retrig_req", 32'(wr_req), 0);
         check("t4_no_retrig_busy", 32'(busy), 0);
         @(negedge clk);
      end

      // reset mid-burst, then a clean command
      start_cmd(0, 0, 24'h55aa55, 256);
      wait_req();
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      wr_data_req = 1'b1;
      repeat (30) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_req", 32'(wr_req), 0);
      check("mid_rst_addr", 32'(wr_addr), 0);
      check("mid_rst_len", 32'(wr_len), 0);
      check("mid_rst_data", 32'(wr_data), 0);
      wr_data_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_done", 32'(done), 0);
      end
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_done", 32'(done), 0);
         check("post_rst_busy", 32'(busy), 0);
      end
      start_cmd(0, 2, 24'h123456, 8);
      serve(2048, 8, 2, 24'h123456, 1'b0);
      finish_cmd();

      // bottom-right corner run
      start_cmd(1000, 767, 24'h0000ff, 100);
`ifdef GPU_CLIP_EN
      serve(786408, 24, 1, 24'h0000ff, 1'b0);
`else
      serve(786408, 24, 1, 24'h0000ff, 1'b0);
      serve(786432, 76, 1, 24'h0000ff, 1'b0);
`endif
      finish_cmd();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
